// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: register-file geometry, default latencies,
// hazard controller FSM states and scoreboard counter sizing.
package arm_pipe_pkg;

  localparam int unsigned REG_AW_DEF   = 4;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned WB_LAT_DEF   = 3;
  localparam int unsigned LOAD_LAT_DEF = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_e;

  // Counter width able to hold the larger of the two issue latencies (min 1 bit).
  function automatic int unsigned cnt_w(input int unsigned wb_lat, input int unsigned ld_lat);
    int unsigned m;
    m = (wb_lat > ld_lat) ? wb_lat : ld_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: counts down to zero, reloads on a write issue, and
// reports busy while nonzero.
module hazard_sb_entry #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt_q, cnt_d;

  // A reload wins over the decrement of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW stall / branch flush controller for the 5-stage ARM pipeline, built on a
// per-register countdown scoreboard.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned WB_LAT      = WB_LAT_DEF,
  parameter int unsigned LOAD_LAT    = LOAD_LAT_DEF,
  parameter int unsigned FWD_EN      = 0,
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_src1,
  input  logic [REG_AW-1:0]   id_src2,
  input  logic                id_two_src,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                branch_taken,
  output logic                hazard,
  output logic                freeze,
  output logic                flush,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int unsigned CW           = cnt_w(WB_LAT, LOAD_LAT);
  localparam int unsigned IDX_N        = 2 ** REG_AW;
  localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

  pipe_state_e         state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [CW-1:0]       lat;
  logic [NUM_REGS-1:0] wr_en;
  logic [IDX_N-1:0]    busy_ext;

  always_comb begin
    lat = '0;
    if (id_mem_r_en) begin
      lat = CW'(LOAD_LAT);
    end else if (FWD_EN == 0) begin
      lat = CW'(WB_LAT);
    end
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_en[r] = issue & id_wb_en & (id_dest == REG_AW'(r));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    hazard_sb_entry #(.CW(CW)) u_entry (
      .clk      (clk),
      .rst_n    (rst),
      .load     (wr_en[g]),
      .load_val (lat),
      .busy     (busy_mask[g])
    );
  end

  // Untracked indices map onto zero-padded slots so they never stall.
  always_comb begin
    busy_ext                 = '0;
    busy_ext[NUM_REGS-1:0]   = busy_mask;
  end

  // Flush and issue are gated by reset so they drop asynchronously with it.
  always_comb begin
    hazard = id_valid & (busy_ext[id_src1] | (id_two_src & busy_ext[id_src2]));
    freeze = rst & hazard & ~branch_taken & (state_q != FLUSH);
    flush  = rst & (branch_taken | (state_q == FLUSH));
    issue  = rst & id_valid & ~freeze & ~flush;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end else if (hazard) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end else if (!hazard) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule
